time_offset_gen: RTL and testbench

Computes the signed time offset between a grandmaster timestamp and the local synchronized time, and drives the offset-write interface of `global_time_sync`. Each sync sample carries the master time from a received sync frame, the measured path delay, and the local time captured at frame reception. The block forms `offset = (master + delay) - local` in the mixed-radix time format and issues one `o_time_offset_wr` pulse per accepted, valid sample. It sits in the HCP time-sync path, between the sync-frame parser/timestamper and `global_time_sync`.

---
 rtl/time_offset_gen.sv | 180 ++++++++++++++++++
 tb/tb_time_offset_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_offset_gen.sv
// time_offset_gen: forms the signed offset (master + delay) - local in the
// mixed-radix time format (41-bit microseconds, 7-bit 8 ns ticks 0..124)
// and issues one offset-write pulse per accepted, valid sample.
module time_offset_gen (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sync_en,
  input  logic [47:0] iv_master_time,
  input  logic [47:0] iv_path_delay,
  input  logic [47:0] iv_local_rx_time,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  input  logic [47:0] iv_offset_limit,
  output logic [48:0] ov_time_offset,
  output logic        o_time_offset_wr,
  output logic [15:0] ov_sample_cnt,
  output logic [15:0] ov_err_cnt,
  output logic [15:0] ov_outlier_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SUB,
    S_ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [47:0] master_q, master_d;
  logic [47:0] delay_q, delay_d;
  logic [47:0] local_q, local_d;
  logic [47:0] target_q, target_d;
  logic [47:0] mag_q, mag_d;
  logic        sign_q, sign_d;
  logic [48:0] offset_q, offset_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] outlier_cnt_q, outlier_cnt_d;

  logic        accept;
  logic        fields_ok;
  logic [7:0]  lo_sum;
  logic [6:0]  lo_add;
  logic        carry;
  logic [40:0] hi_add;
  logic        target_ge;
  logic [47:0] sub_a, sub_b;
  logic [6:0]  lo_sub;
  logic        borrow;
  logic [40:0] hi_sub;
  logic        outlier_hit;
  logic        write_now;

  assign o_sample_ready = (state_q == S_IDLE) && i_sync_en;
  assign accept         = i_sample_valid && o_sample_ready;

  // Field check and mixed-radix addition of master time and path delay.
  always_comb begin
    fields_ok = (master_q[6:0] <= 7'd124) && (delay_q[6:0] <= 7'd124) &&
                (local_q[6:0] <= 7'd124);
    lo_sum = {1'b0, master_q[6:0]} + {1'b0, delay_q[6:0]};
    carry  = 1'b0;
    lo_add = lo_sum[6:0];
    if (lo_sum >= 8'd125) begin
      lo_add = 7'(lo_sum - 8'd125);
      carry  = 1'b1;
    end
    hi_add = master_q[47:7] + delay_q[47:7] + {40'd0, carry};
  end

  // Magnitude subtract: larger operand minus smaller, borrowing 125 ticks.
  always_comb begin
    target_ge = (target_q >= local_q);
    sub_a     = target_ge ? target_q : local_q;
    sub_b     = target_ge ? local_q : target_q;
    borrow    = 1'b0;
    lo_sub    = sub_a[6:0] - sub_b[6:0];
    if (sub_a[6:0] < sub_b[6:0]) begin
      lo_sub = sub_a[6:0] + 7'd125 - sub_b[6:0];
      borrow = 1'b1;
    end
    hi_sub = sub_a[47:7] - sub_b[47:7] - {40'd0, borrow};
  end

  assign outlier_hit = (iv_offset_limit != 48'd0) && (mag_q > iv_offset_limit);

  // Next-state and register updates; dropping the enable abandons the sample.
  always_comb begin
    state_d       = state_q;
    master_d      = master_q;
    delay_d       = delay_q;
    local_d       = local_q;
    target_d      = target_q;
    mag_d         = mag_q;
    sign_d        = sign_q;
    offset_d      = offset_q;
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    outlier_cnt_d = outlier_cnt_q;
    write_now     = 1'b0;
    if (!i_sync_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            master_d     = iv_master_time;
            delay_d      = iv_path_delay;
            local_d      = iv_local_rx_time;
            sample_cnt_d = sample_cnt_q + 16'd1;
            state_d      = S_ADD;
          end
        end
        S_ADD: begin
          if (!fields_ok) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            target_d = {hi_add, lo_add};
            state_d  = S_SUB;
          end
        end
        S_SUB: begin
          sign_d  = ~target_ge;
          mag_d   = {hi_sub, lo_sub};
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (mag_q != 48'd0) begin
            if (outlier_hit) begin
              if (outlier_cnt_q != 16'hFFFF) outlier_cnt_d = outlier_cnt_q + 16'd1;
            end else begin
              offset_d  = {sign_q, mag_q};
              write_now = 1'b1;
            end
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, sample and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      master_q      <= '0;
      delay_q       <= '0;
      local_q       <= '0;
      target_q      <= '0;
      mag_q         <= '0;
      sign_q        <= 1'b0;
      offset_q      <= '0;
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      outlier_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      master_q      <= master_d;
      delay_q       <= delay_d;
      local_q       <= local_d;
      target_q      <= target_d;
      mag_q         <= mag_d;
      sign_q        <= sign_d;
      offset_q      <= offset_d;
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      outlier_cnt_q <= outlier_cnt_d;
    end
  end

  // The new offset is presented during the write cycle and held afterwards.
  assign o_time_offset_wr = write_now;
  assign ov_time_offset   = write_now ? {sign_q, mag_q} : offset_q;
  assign ov_sample_cnt    = sample_cnt_q;
  assign ov_err_cnt       = err_cnt_q;
  assign ov_outlier_cnt   = outlier_cnt_q;

endmodule

// File: tb/tb_time_offset_gen.sv
// Testbench for time_offset_gen: directed samples, expected offsets queued
// at issue time and consumed by an independent write monitor.
module tb_time_offset_gen;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_sync_en;
   logic [47:0] iv_master_time;
   logic [47:0] iv_path_delay;
   logic [47:0] iv_local_rx_time;
   logic        i_sample_valid;
   logic        o_sample_ready;
   logic [47:0] iv_offset_limit;
   logic [48:0] ov_time_offset;
   logic        o_time_offset_wr;
   logic [15:0] ov_sample_cnt;
   logic [15:0] ov_err_cnt;
   logic [15:0] ov_outlier_cnt;

   int          testsRun = 0;
   int          failCount = 0;
   int          expSamples = 0;
   logic [48:0] expQ[$];
   logic        prevWr = 1'b0;

   time_offset_gen dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_sync_en        (i_sync_en),
      .iv_master_time   (iv_master_time),
      .iv_path_delay    (iv_path_delay),
      .iv_local_rx_time (iv_local_rx_time),
      .i_sample_valid   (i_sample_valid),
      .o_sample_ready   (o_sample_ready),
      .iv_offset_limit  (iv_offset_limit),
      .ov_time_offset   (ov_time_offset),
      .o_time_offset_wr (o_time_offset_wr),
      .ov_sample_cnt    (ov_sample_cnt),
      .ov_err_cnt       (ov_err_cnt),
      .ov_outlier_cnt   (ov_outlier_cnt)
   );

   // 125 MHz clock
   initial i_clk = 1'b0;
   always #4 i_clk = ~i_clk;

   // Builds a time value from microseconds and 8 ns ticks
   function automatic logic [47:0] tv(input int hi, input int lo);
      return {41'(hi), 7'(lo)};
   endfunction

   // One comparison: counts it and reports a failure line on mismatch
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Presents one sample until accepted; queues the expected write if any
   task automatic applyStimulus(input logic [47:0] m, input logic [47:0] d,
                                input logic [47:0] l, input bit expectWr,
                                input logic [48:0] expOff);
      int budget = 0;
      while (!o_sample_ready && budget < 20) begin
         waitCycles(1);
         budget++;
      end
      if (!o_sample_ready) begin
         checkOutput("ready_timeout", 64'(o_sample_ready), 64'd1);
      end else begin
         if (expectWr) expQ.push_back(expOff);
         expSamples++;
         iv_master_time   = m;
         iv_path_delay    = d;
         iv_local_rx_time = l;
         i_sample_valid   = 1'b1;
         waitCycles(1);
         i_sample_valid   = 1'b0;
      end
   endtask

   // Write monitor: every pulse must match the oldest queued expectation
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         prevWr <= 1'b0;
      end else begin
         if (o_time_offset_wr) begin
            checkOutput("wr_spacing", 64'(prevWr), 64'd0);
            if (expQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL unexpected_wr: got offset %h, required no write", ov_time_offset);
            end else begin
               checkOutput("offset", 64'(ov_time_offset), 64'(expQ.pop_front()));
            end
         end
         prevWr <= o_time_offset_wr;
      end
   end

   // Safety net against a stalled run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int accepts;
      i_rst_n          = 1'b0;
      i_sync_en        = 1'b1;
      i_sample_valid   = 1'b0;
      iv_master_time   = '0;
      iv_path_delay    = '0;
      iv_local_rx_time = '0;
      iv_offset_limit  = '0;
      waitCycles(3);
      checkOutput("rst_offset", 64'(ov_time_offset), 64'd0);
      checkOutput("rst_wr", 64'(o_time_offset_wr), 64'd0);
      checkOutput("rst_cnts", {16'd0, ov_sample_cnt, ov_err_cnt, ov_outlier_cnt}, 64'd0);
      i_rst_n = 1'b1;
      waitCycles(1);
      checkOutput("rst_ready", 64'(o_sample_ready), 64'd1);

      $display("[TB] positive offset with carry");
      applyStimulus(tv(1000, 10), tv(0, 120), tv(1000, 0), 1'b1, 49'h0_0000_0000_0085);
      checkOutput("t1_ready", 64'(o_sample_ready), 64'd0);
      checkOutput("t1_wr", 64'(o_time_offset_wr), 64'd0);
      waitCycles(1);
      checkOutput("t2_wr", 64'(o_time_offset_wr), 64'd0);
      waitCycles(1);
      checkOutput("t3_wr", 64'(o_time_offset_wr), 64'd1);
      waitCycles(1);
      checkOutput("t4_ready", 64'(o_sample_ready), 64'd1);
      checkOutput("t4_wr", 64'(o_time_offset_wr), 64'd0);
      checkOutput("t4_hold", 64'(ov_time_offset), 64'h85);
      checkOutput("t4_samples", 64'(ov_sample_cnt), 64'(expSamples));

      $display("[TB] negative offset");
      applyStimulus(tv(500, 3), tv(0, 0), tv(500, 7), 1'b1, 49'h1_0000_0000_0004);
      waitCycles(3);

      $display("[TB] borrow in subtract");
      applyStimulus(tv(2, 0), tv(0, 0), tv(1, 124), 1'b1, 49'h0_0000_0000_0001);
      waitCycles(3);

      $display("[TB] zero offset");
      applyStimulus(tv(300, 5), tv(0, 0), tv(300, 5), 1'b0, '0);
      waitCycles(3);

      $display("[TB] outlier suppression");
      iv_offset_limit = 48'h80;
      applyStimulus(tv(10, 0), tv(0, 0), tv(8, 0), 1'b0, '0);
      waitCycles(2);
      checkOutput("outlier_pre", 64'(ov_outlier_cnt), 64'd0);
      waitCycles(1);
      checkOutput("outlier_cnt", 64'(ov_outlier_cnt), 64'd1);
      checkOutput("outlier_hold", 64'(ov_time_offset), 64'h1);

      $display("[TB] offset equal to limit");
      iv_offset_limit = 48'h100;
      applyStimulus(tv(10, 0), tv(0, 0), tv(8, 0), 1'b1, 49'h0_0000_0000_0100);
      waitCycles(3);
      iv_offset_limit = '0;

      $display("[TB] malformed field");
      applyStimulus(tv(5, 125), tv(0, 0), tv(5, 0), 1'b0, '0);
      checkOutput("mal_busy", 64'(o_sample_ready), 64'd0);
      waitCycles(1);
      checkOutput("mal_ready", 64'(o_sample_ready), 64'd1);
      checkOutput("mal_err", 64'(ov_err_cnt), 64'd1);

      $display("[TB] back-to-back samples");
      iv_master_time   = tv(100, 4);
      iv_path_delay    = tv(0, 1);
      iv_local_rx_time = tv(100, 0);
      i_sample_valid   = 1'b1;
      accepts = 0;
      for (int c = 0; c < 16; c++) begin
         if (o_sample_ready) begin
            accepts++;
            expSamples++;
            expQ.push_back(49'h5);
         end
         waitCycles(1);
      end
      i_sample_valid = 1'b0;
      waitCycles(1);
      checkOutput("b2b_accepts", 64'(accepts), 64'd4);
      checkOutput("b2b_samples", 64'(ov_sample_cnt), 64'(expSamples));

      $display("[TB] enable dropped during SUB");
      applyStimulus(tv(20, 0), tv(0, 0), tv(10, 0), 1'b0, '0);
      waitCycles(1);
      i_sync_en = 1'b0;
      #1;
      checkOutput("abort_ready_low", 64'(o_sample_ready), 64'd0);
      waitCycles(1);
      i_sync_en = 1'b1;
      #1;
      checkOutput("abort_idle", 64'(o_sample_ready), 64'd1);
      waitCycles(3);
      checkOutput("abort_cnts", {16'd0, ov_sample_cnt, ov_err_cnt, ov_outlier_cnt},
                  {16'd0, 16'(expSamples), 16'd1, 16'd1});

      $display("[TB] reset mid-operation");
      applyStimulus(tv(40, 0), tv(0, 0), tv(30, 0), 1'b0, '0);
      waitCycles(1);
      i_rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_offset", 64'(ov_time_offset), 64'd0);
      checkOutput("mid_rst_wr", 64'(o_time_offset_wr), 64'd0);
      checkOutput("mid_rst_cnts", {16'd0, ov_sample_cnt, ov_err_cnt, ov_outlier_cnt}, 64'd0);
      checkOutput("mid_rst_ready", 64'(o_sample_ready), 64'd1);
      waitCycles(2);
      i_rst_n = 1'b1;
      expSamples = 0;
      waitCycles(4);
      checkOutput("post_rst_samples", 64'(ov_sample_cnt), 64'd0);
      checkOutput("post_rst_offset", 64'(ov_time_offset), 64'd0);

      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
